// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer: in-order FIFO from GSAU psums to the veggie write port.
// Optional same-cycle empty bypass enabled by WB_BUFFER_BYPASS_EN.
module gsau_wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 512,
    parameter int DST_W  = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [DATA_W-1:0]        wb_psum,
    input  logic [DST_W-1:0]         wb_wbdst,
    input  logic                     wb_valid,
    output logic                     wb_output_ready,
    output logic                     rf_wen,
    output logic [DST_W-1:0]         rf_wdst,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic                     rf_ready,
    output logic                     sb_clr_valid,
    output logic [DST_W-1:0]         sb_clr_vdst,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DST_W + DATA_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_sb_valid;
    logic [DST_W-1:0] r_sb_vdst;

    logic             w_full;
    logic             w_empty;
    logic [EW-1:0]    w_head_ent;
    logic             w_wen;
    logic [DST_W-1:0] w_wdst;
    logic [DATA_W-1:0] w_wdata;
    logic             w_bypass;
    logic             w_fire;
    logic             w_pop;
    logic             w_push;

    assign w_full     = (r_count == FULL);
    assign w_empty    = (r_count == '0);
    assign w_head_ent = r_mem[r_head];

    // Ready comes from registered count only, so full blocks push even on a pop.
    assign wb_output_ready = !w_full;

    always_comb begin
        w_wen    = !w_empty;
        w_wdst   = w_empty ? '0 : w_head_ent[EW-1:DATA_W];
        w_wdata  = w_empty ? '0 : w_head_ent[DATA_W-1:0];
        w_bypass = 1'b0;
`ifdef WB_BUFFER_BYPASS_EN
        if (w_empty) begin
            w_wen    = wb_valid;
            w_wdst   = wb_valid ? wb_wbdst : '0;
            w_wdata  = wb_valid ? wb_psum  : '0;
            w_bypass = wb_valid && rf_ready;
        end
`endif
    end

    assign w_fire = w_wen && rf_ready;
    assign w_pop  = w_fire && !w_empty;
    assign w_push = wb_valid && !w_full && !w_bypass;

    assign rf_wen       = w_wen;
    assign rf_wdst      = w_wdst;
    assign rf_wdata     = w_wdata;
    assign sb_clr_valid = r_sb_valid;
    assign sb_clr_vdst  = r_sb_vdst;
    assign occupancy    = r_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sb_valid <= 1'b0;
            r_sb_vdst  <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + PW'(1);
            if (w_pop)
                r_head <= r_head + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_sb_valid <= w_fire;
            if (w_fire)
                r_sb_vdst <= w_wdst;
        end
    end

    // Storage is not reset; entries are only visible through count.
    always_ff @(posedge CLK) begin
        if (nRST && w_push)
            r_mem[r_tail] <= {wb_wbdst, wb_psum};
    end

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Directed bench for gsau_wb_buffer.
// Expectations follow the bypass macro when WB_BUFFER_BYPASS_EN is defined.
module tb_gsau_wb_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 512;
    localparam int DST_W  = 8;
`ifdef WB_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              nRST;
    logic [DATA_W-1:0] wb_psum;
    logic [DST_W-1:0]  wb_wbdst;
    logic              wb_valid;
    logic              wb_output_ready;
    logic              rf_wen;
    logic [DST_W-1:0]  rf_wdst;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_ready;
    logic              sb_clr_valid;
    logic [DST_W-1:0]  sb_clr_vdst;
    logic [2:0]        occupancy;

    int n_cmp = 0;
    int n_bad = 0;

    gsau_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .DST_W(DST_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .wb_psum(wb_psum), .wb_wbdst(wb_wbdst), .wb_valid(wb_valid),
        .wb_output_ready(wb_output_ready),
        .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
        .rf_ready(rf_ready),
        .sb_clr_valid(sb_clr_valid), .sb_clr_vdst(sb_clr_vdst),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (nRST && wb_valid && wb_output_ready)
            assert (occupancy != 3'(DEPTH))
            else $error("FAIL push_when_full occ=%0d", occupancy);
    end

    task automatic check(input string tag,
                         input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] w);
        return {16{w}};
    endfunction

    initial begin
        logic [DATA_W-1:0] dead;
        dead     = pat(32'hDEADBEEF);
        nRST     = 1'b0;
        wb_valid = 1'b0;
        wb_psum  = '0;
        wb_wbdst = '0;
        rf_ready = 1'b0;
        tick();
        tick();
        nRST = 1'b1;

        // idle after reset
        for (int i = 0; i < 3; i++) begin
            check("idle_ready", wb_output_ready, 1);
            check("idle_wen", rf_wen, 0);
            check("idle_occ", occupancy, 0);
            check("idle_sb", sb_clr_valid, 0);
            check("idle_wdata", rf_wdata, 0);
            tick();
        end

        // single push, head/tail move to 1
        wb_valid = 1'b1;
        wb_wbdst = 8'h05;
        wb_psum  = dead;
        tick();
        wb_valid = 1'b0;
        wb_psum  = '0;
        rf_ready = 1'b1;
        #1;
        check("one_wen", rf_wen, 1);
        check("one_wdst", rf_wdst, 8'h05);
        check("one_wdata", rf_wdata, dead);
        check("one_occ", occupancy, 1);
        tick();
        check("one_sb", sb_clr_valid, 1);
        check("one_vdst", sb_clr_vdst, 8'h05);
        check("one_occ0", occupancy, 0);
        check("one_wen0", rf_wen, 0);
        tick();
        check("one_sb0", sb_clr_valid, 0);
        check("one_vdst_hold", sb_clr_vdst, 8'h05);

        // fill to full with wrap (slots 1,2,3,0)
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1;
            wb_wbdst = 8'(i);
            wb_psum  = pat(32'(i));
            tick();
        end
        check("full_occ", occupancy, 4);
        check("full_ready", wb_output_ready, 0);
        wb_wbdst = 8'h09;
        wb_psum  = pat(32'h9);
        tick();
        check("full_block_occ", occupancy, 4);
        check("full_head", rf_wdst, 1);
        // full + pop in the same cycle still refuses the push
        rf_ready = 1'b1;
        #1;
        check("full_pop_ready", wb_output_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("drain_wdst%0d", i), rf_wdst, 8'(i));
            check($sformatf("drain_wdata%0d", i), rf_wdata, pat(32'(i)));
            tick();
            wb_valid = 1'b0;
            check($sformatf("drain_sb%0d", i), sb_clr_valid, 1);
            check($sformatf("drain_vdst%0d", i), sb_clr_vdst, 8'(i));
            check($sformatf("drain_occ%0d", i), occupancy, 3'(4 - i));
        end
        tick();
        check("drain_sb_end", sb_clr_valid, 0);

        // steady stream of 10
        rf_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wb_valid = 1'b1;
            wb_wbdst = 8'(k);
            wb_psum  = pat(32'(k + 100));
            #1;
            if (BYP) begin
                check($sformatf("strm_wdst%0d", k), rf_wdst, 8'(k));
            end else if (k > 0) begin
                check($sformatf("strm_wdst%0d", k), rf_wdst, 8'(k - 1));
                check($sformatf("strm_wdata%0d", k), rf_wdata,
                      pat(32'(k + 99)));
            end
            tick();
            check($sformatf("strm_occ%0d", k), occupancy, BYP ? 0 : 1);
            if (BYP || k > 0) begin
                check($sformatf("strm_sb%0d", k), sb_clr_valid, 1);
                check($sformatf("strm_vdst%0d", k), sb_clr_vdst,
                      BYP ? 8'(k) : 8'(k - 1));
            end
        end
        wb_valid = 1'b0;
        #1;
        if (!BYP) begin
            check("strm_last_wdst", rf_wdst, 8'd9);
            tick();
            check("strm_last_vdst", sb_clr_vdst, 8'd9);
        end
        tick();
        check("strm_occ_end", occupancy, 0);

        // reset during a pop
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1;
            wb_wbdst = 8'(8'h30 + i);
            wb_psum  = pat(32'(i + 48));
            tick();
        end
        wb_valid = 1'b0;
        check("rst_pre_occ", occupancy, 3);
        rf_ready = 1'b1;
        nRST     = 1'b0;
        tick();
        nRST = 1'b1;
        check("rst_occ", occupancy, 0);
        check("rst_wen", rf_wen, 0);
        check("rst_sb", sb_clr_valid, 0);
        check("rst_vdst", sb_clr_vdst, 0);
        check("rst_wdst", rf_wdst, 0);
        check("rst_ready", wb_output_ready, 1);
        rf_ready = 1'b0;
        wb_valid = 1'b1;
        wb_wbdst = 8'h7F;
        wb_psum  = pat(32'h7F7F0001);
        tick();
        wb_valid = 1'b0;
        check("post_wen", rf_wen, 1);
        check("post_wdst", rf_wdst, 8'h7F);
        check("post_wdata", rf_wdata, pat(32'h7F7F0001));
        rf_ready = 1'b1;
        tick();
        check("post_sb", sb_clr_valid, 1);
        check("post_vdst", sb_clr_vdst, 8'h7F);
        check("post_occ", occupancy, 0);

`ifdef WB_BUFFER_BYPASS_EN
        tick();
        wb_valid = 1'b1;
        wb_wbdst = 8'h22;
        wb_psum  = pat(32'h22222222);
        rf_ready = 1'b1;
        #1;
        check("byp_wen", rf_wen, 1);
        check("byp_wdst", rf_wdst, 8'h22);
        check("byp_wdata", rf_wdata, pat(32'h22222222));
        tick();
        wb_valid = 1'b0;
        check("byp_occ", occupancy, 0);
        check("byp_sb", sb_clr_valid, 1);
        check("byp_vdst", sb_clr_vdst, 8'h22);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
